// File: rtl/sdm_chan_ctrl.sv
// sdm_chan_ctrl: loads channel words {N, frac} into the PLL sigma-delta modulator, then waits out settling.
// Optional warm-retune ramp is built in when SDM_CHAN_CTRL_RAMP_EN is defined.
module sdm_chan_ctrl #(
  parameter int W          = 16,
  parameter int NW         = 6,
  parameter int INIT_CYC   = 4,
  parameter int SETTLE_CYC = 1000,
  parameter int RAMP_STEP  = 256,
  parameter int RAMP_DIV   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [NW-1:0] cfg_n,
  input  logic [W-1:0]  cfg_frac,
  output logic          sdm_rstn,
  output logic [NW-1:0] sdm_n,
  output logic [W-1:0]  sdm_din,
  output logic          busy,
  output logic          settled,
  output logic          done
);

`ifdef SDM_CHAN_CTRL_RAMP_EN
  typedef enum logic [2:0] {
    ST_COLD = 3'd0, ST_INIT = 3'd1, ST_RAMP = 3'd2, ST_SETTLE = 3'd3, ST_LOCK = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_COLD = 3'd0, ST_INIT = 3'd1, ST_SETTLE = 3'd3, ST_LOCK = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [19:0]   cnt_q, cnt_d;
  logic          sdm_rstn_q, sdm_rstn_d;
  logic [NW-1:0] sdm_n_q, sdm_n_d;
  logic [W-1:0]  sdm_din_q, sdm_din_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          busy_q, busy_d;
  logic          settled_q, settled_d;
  logic          done_q, done_d;
  logic          xfer_s;

  assign xfer_s = cfg_valid & cfg_ready_q;

`ifdef SDM_CHAN_CTRL_RAMP_EN
  localparam int CW = NW + W;
  localparam logic [CW:0] STEP_V = (CW+1)'(RAMP_STEP);

  logic [CW-1:0] tgt_q, tgt_d;
  logic [CW-1:0] cur_s;
  logic [CW:0]   diff_s, dabs_s;

  // Difference is taken one bit wider so it never wraps; its MSB is the sign.
  assign cur_s  = {sdm_n_q, sdm_din_q};
  assign diff_s = {1'b0, tgt_q} - {1'b0, cur_s};
  assign dabs_s = diff_s[CW] ? ((CW+1)'(0) - diff_s) : diff_s;
`endif

  // Next-state, counter and output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sdm_rstn_d = sdm_rstn_q;
    sdm_n_d    = sdm_n_q;
    sdm_din_d  = sdm_din_q;
`ifdef SDM_CHAN_CTRL_RAMP_EN
    tgt_d      = tgt_q;
`endif
    case (state_q)
      ST_COLD: begin
        if (xfer_s) begin
          sdm_n_d    = cfg_n;
          sdm_din_d  = cfg_frac;
          sdm_rstn_d = 1'b0;
          cnt_d      = 20'(INIT_CYC - 1);
          state_d    = ST_INIT;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_INIT: begin
        if (cnt_q == 20'd0) begin
          sdm_rstn_d = 1'b1;
          cnt_d      = 20'(SETTLE_CYC - 1);
          state_d    = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
`ifdef SDM_CHAN_CTRL_RAMP_EN
      ST_RAMP: begin
        if (cnt_q == 20'd0) begin
          if (dabs_s <= STEP_V) begin
            {sdm_n_d, sdm_din_d} = tgt_q;
            cnt_d                = 20'(SETTLE_CYC - 1);
            state_d              = ST_SETTLE;
          end else if (diff_s[CW]) begin
            {sdm_n_d, sdm_din_d} = cur_s - STEP_V[CW-1:0];
            cnt_d                = 20'(RAMP_DIV - 1);
          end else begin
            {sdm_n_d, sdm_din_d} = cur_s + STEP_V[CW-1:0];
            cnt_d                = 20'(RAMP_DIV - 1);
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
`endif
      ST_SETTLE: begin
        if (cnt_q == 20'd0) begin
          state_d = ST_LOCK;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      ST_LOCK: begin
        if (xfer_s) begin
`ifdef SDM_CHAN_CTRL_RAMP_EN
          tgt_d   = {cfg_n, cfg_frac};
          cnt_d   = 20'(RAMP_DIV - 1);
          state_d = ST_RAMP;
`else
          sdm_n_d   = cfg_n;
          sdm_din_d = cfg_frac;
          cnt_d     = 20'(SETTLE_CYC - 1);
          state_d   = ST_SETTLE;
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d    = ST_COLD;
        sdm_rstn_d = 1'b0;
      end
    endcase

    cfg_ready_d = (state_d == ST_COLD) || (state_d == ST_LOCK);
    busy_d      = ~cfg_ready_d;
    settled_d   = (state_d == ST_LOCK);
    done_d      = settled_d && (state_q != ST_LOCK);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COLD;
      cnt_q       <= 20'd0;
      sdm_rstn_q  <= 1'b0;
      sdm_n_q     <= '0;
      sdm_din_q   <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      settled_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sdm_rstn_q  <= sdm_rstn_d;
      sdm_n_q     <= sdm_n_d;
      sdm_din_q   <= sdm_din_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      settled_q   <= settled_d;
      done_q      <= done_d;
    end
  end

`ifdef SDM_CHAN_CTRL_RAMP_EN
  // Ramp target register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q <= '0;
    end else begin
      tgt_q <= tgt_d;
    end
  end
`endif

  assign cfg_ready = cfg_ready_q;
  assign sdm_rstn  = sdm_rstn_q;
  assign sdm_n     = sdm_n_q;
  assign sdm_din   = sdm_din_q;
  assign busy      = busy_q;
  assign settled   = settled_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sdm_chan_ctrl.sv
// Self-checking bench for sdm_chan_ctrl: expected lock events are queued at each transfer
// and compared when the DUT pulses done.
module tb_sdm_chan_ctrl;
  localparam int W = 16, NW = 6, INIT_CYC = 4, SETTLE_CYC = 1000, RAMP_STEP = 256, RAMP_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic [NW-1:0] cfg_n = '0;
  logic [W-1:0] cfg_frac = '0;
  logic cfg_ready, sdm_rstn, busy, settled, done;
  logic [NW-1:0] sdm_n;
  logic [W-1:0] sdm_din;

  sdm_chan_ctrl #(.W(W), .NW(NW), .INIT_CYC(INIT_CYC), .SETTLE_CYC(SETTLE_CYC),
                  .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_n(cfg_n), .cfg_frac(cfg_frac), .sdm_rstn(sdm_rstn), .sdm_n(sdm_n),
    .sdm_din(sdm_din), .busy(busy), .settled(settled), .done(done));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NW-1:0] n;
    logic [W-1:0]  f;
    int unsigned   t;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  logic [NW+W-1:0] model_cur = '0;
  bit cold = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cycles from transfer edge to the done edge, derived from the channel arithmetic.
  function automatic int unsigned exp_delay(input logic [NW+W-1:0] cur, input logic [NW+W-1:0] tgt,
                                            input bit is_cold);
    int unsigned d;
    int unsigned steps;
    if (is_cold) return INIT_CYC + SETTLE_CYC;
`ifdef SDM_CHAN_CTRL_RAMP_EN
    d = (tgt > cur) ? int'(tgt - cur) : int'(cur - tgt);
    steps = (d == 0) ? 1 : (d + RAMP_STEP - 1) / RAMP_STEP;
    return steps * RAMP_DIV + SETTLE_CYC;
`else
    d = 0;
    steps = 0;
    return SETTLE_CYC + d + steps;
`endif
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check_val("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("done_n", 32'(sdm_n), 32'(e.n));
        check_val("done_frac", 32'(sdm_din), 32'(e.f));
        check_val("done_cycle", cyc, e.t);
        check_val("done_settled", 32'(settled), 32'd1);
        check_val("done_rstn", 32'(sdm_rstn), 32'd1);
      end
    end
  end

  task automatic wait_to(input int unsigned e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge t.
  task automatic do_xfer(input logic [NW-1:0] n, input logic [W-1:0] f, output int unsigned t);
    bit ok;
    logic [NW+W-1:0] prev;
    exp_t e;
    ok = 1'b0;
    t = 0;
    cfg_n = n;
    cfg_frac = f;
    cfg_valid = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check_val("xfer_timeout", 32'd0, 32'd1);
      cfg_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      t = cyc;
      cfg_valid = 1'b0;
      prev = model_cur;
      e.n = n;
      e.f = f;
      e.t = t + exp_delay(prev, {n, f}, cold);
      sb.push_back(e);
      check_val("xfer_busy", 32'(busy), 32'd1);
      check_val("xfer_ready", 32'(cfg_ready), 32'd0);
      check_val("xfer_settled", 32'(settled), 32'd0);
      check_val("xfer_rstn", 32'(sdm_rstn), cold ? 32'd0 : 32'd1);
`ifdef SDM_CHAN_CTRL_RAMP_EN
      check_val("xfer_word", 32'({sdm_n, sdm_din}), cold ? 32'({n, f}) : 32'(prev));
`else
      check_val("xfer_word", 32'({sdm_n, sdm_din}), 32'({n, f}));
`endif
      model_cur = {n, f};
      cold = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_lock();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (settled) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val("lock_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check_val("done_one_cycle", 32'(done), 32'd0);
      check_val("lock_settled", 32'(settled), 32'd1);
      check_val("lock_ready", 32'(cfg_ready), 32'd1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_rstn"}, 32'(sdm_rstn), 32'd0);
    check_val({tag, "_n"}, 32'(sdm_n), 32'd0);
    check_val({tag, "_din"}, 32'(sdm_din), 32'd0);
    check_val({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_settled"}, 32'(settled), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Cold load: sdm_rstn must rise exactly INIT_CYC edges after the transfer.
  task automatic cold_load(output int unsigned t);
    do_xfer(6'd31, 16'd26625, t);
    wait_to(t + INIT_CYC - 1);
    check_val("cold_rstn_low", 32'(sdm_rstn), 32'd0);
    wait_to(t + INIT_CYC);
    check_val("cold_rstn_high", 32'(sdm_rstn), 32'd1);
    check_val("cold_busy", 32'(busy), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int unsigned t, t2;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // T1 cold load with T2 backpressure held during SETTLE.
    cold_load(t);
    cfg_valid = 1'b1;
    cfg_n = 6'd20;
    cfg_frac = 16'd26625;
    wait_to(t + 500);
    check_val("bp_n_mid", 32'(sdm_n), 32'd31);
    check_val("bp_ready_mid", 32'(cfg_ready), 32'd0);
    wait_to(t + INIT_CYC + SETTLE_CYC - 1);
    check_val("bp_n_late", 32'(sdm_n), 32'd31);
    check_val("bp_settled_late", 32'(settled), 32'd0);
    @(negedge clk);
    do_xfer(6'd20, 16'd26625, t2);
    check_val("bp_xfer_edge", t2, t + INIT_CYC + SETTLE_CYC + 1);
    wait_lock();

    // Back to 31/26625, then the 32/0 retune (ramped or direct).
    do_xfer(6'd31, 16'd26625, t);
    wait_lock();
    do_xfer(6'd32, 16'd0, t);
`ifdef SDM_CHAN_CTRL_RAMP_EN
    wait_to(t + RAMP_DIV - 1);
    check_val("ramp_before_first", 32'({sdm_n, sdm_din}), 32'({6'd31, 16'd26625}));
    wait_to(t + RAMP_DIV);
    check_val("ramp_first_step", 32'({sdm_n, sdm_din}), 32'({6'd31, 16'd26881}));
    wait_to(t + 151 * RAMP_DIV);
    check_val("ramp_151_steps", 32'({sdm_n, sdm_din}), 32'({6'd31, 16'd65281}));
    wait_to(t + 152 * RAMP_DIV);
    check_val("ramp_last_step", 32'({sdm_n, sdm_din}), 32'({6'd32, 16'd0}));
    @(negedge clk);
`endif
    wait_lock();

    // Equal target and single small downward step.
    do_xfer(6'd31, 16'd26625, t);
    wait_lock();
    do_xfer(6'd31, 16'd26625, t);
    wait_lock();
    do_xfer(6'd31, 16'd26369, t);
    wait_lock();

    // T6 reset while the retune is in progress.
    do_xfer(6'd20, 16'd0, t);
    wait_to(t + 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    cold = 1'b1;
    model_cur = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("postrst");
    cold_load(t);
    wait_lock();

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
